// File: rtl/otg_hpi_cycle_ctrl.sv
// HPI bus-cycle engine for the CY7C67200: turns single read/write requests into
// timed cs_n/rd_n/wr_n strobe sequences and sequences the chip hardware reset.
module otg_hpi_cycle_ctrl #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 2,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 2,
  parameter int unsigned RESET_CYC    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic        chip_rst_req,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic        otg_rst_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic [2:0]  dbg_state
);

  // Handshake: a request is taken on a rising clk edge where req_valid and
  // req_ready are both 1; req_ready is high only while idle, and the req_*
  // inputs are ignored at every other time.

  // Counter reload values (duration - 1); a zero duration behaves as one cycle.
  localparam logic [7:0] SETUP_LD  = (SETUP_CYC  > 1) ? 8'(SETUP_CYC  - 1) : 8'd0;
  localparam logic [7:0] STROBE_LD = (STROBE_CYC > 1) ? 8'(STROBE_CYC - 1) : 8'd0;
  localparam logic [7:0] HOLD_LD   = (HOLD_CYC   > 1) ? 8'(HOLD_CYC   - 1) : 8'd0;
  localparam logic [7:0] RESET_LD  = (RESET_CYC  > 1) ? 8'(RESET_CYC  - 1) : 8'd0;
  // The idle cycle with req_ready high is the last recovery cycle, so RECOVER
  // itself runs one cycle short and is skipped entirely for a 1-cycle recovery.
  localparam logic [7:0] REC_LD    = (RECOVERY_CYC > 2) ? 8'(RECOVERY_CYC - 2) : 8'd0;
  localparam bit         REC_SKIP  = (RECOVERY_CYC <= 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_HOLD    = 3'd3,
    S_RECOVER = 3'd4,
    S_CHIPRST = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        done;
  logic        enter_recover;
  logic        ready_d, rsp_valid_d, cs_n_d, rd_n_d, wr_n_d, rst_n_d, oe_d;
  logic [1:0]  addr_d;
  logic [15:0] rdata_d, dout_d;

  assign done      = (cnt_q == 8'd0);
  assign dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = done ? cnt_q : cnt_q - 8'd1;
    wr_d          = wr_q;
    enter_recover = 1'b0;
    ready_d       = req_ready;
    rsp_valid_d   = 1'b0;
    rdata_d       = rsp_rdata;
    addr_d        = otg_addr;
    cs_n_d        = otg_cs_n;
    rd_n_d        = otg_rd_n;
    wr_n_d        = otg_wr_n;
    rst_n_d       = otg_rst_n;
    dout_d        = otg_data_out;
    oe_d          = otg_data_oe;

    case (state_q)
      S_IDLE: begin
        if (chip_rst_req) begin
          state_d = S_CHIPRST;
          cnt_d   = RESET_LD;
          rst_n_d = 1'b0;
          ready_d = 1'b0;
        end else if (req_valid && req_ready) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          wr_d    = req_write;
          addr_d  = req_addr;
          cs_n_d  = 1'b0;
          oe_d    = req_write;
          dout_d  = req_wdata;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_SETUP: begin
        if (done) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
          wr_n_d  = ~wr_q;
          rd_n_d  = wr_q;
        end
      end
      S_STROBE: begin
        if (done) begin
          state_d     = S_HOLD;
          cnt_d       = HOLD_LD;
          wr_n_d      = 1'b1;
          rd_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          if (!wr_q) rdata_d = otg_data_in;
        end
      end
      S_HOLD: begin
        if (done) begin
          cs_n_d        = 1'b1;
          oe_d          = 1'b0;
          enter_recover = 1'b1;
        end
      end
      S_RECOVER: begin
        if (done) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_CHIPRST: begin
        if (done) begin
          rst_n_d       = 1'b1;
          enter_recover = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_recover) begin
      if (REC_SKIP) begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end else begin
        state_d = S_RECOVER;
        cnt_d   = REC_LD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      wr_q         <= 1'b0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 16'd0;
      otg_addr     <= 2'd0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_rst_n    <= 1'b1;
      otg_data_out <= 16'd0;
      otg_data_oe  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      req_ready    <= ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rdata_d;
      otg_addr     <= addr_d;
      otg_cs_n     <= cs_n_d;
      otg_rd_n     <= rd_n_d;
      otg_wr_n     <= wr_n_d;
      otg_rst_n    <= rst_n_d;
      otg_data_out <= dout_d;
      otg_data_oe  <= oe_d;
    end
  end

endmodule

// File: tb/tb_otg_hpi_cycle_ctrl.sv
// Directed bench for otg_hpi_cycle_ctrl: default timing, read capture, chip reset,
// async abort, plus accept-rate checks on (3,4,2,1) and all-zero parameter builds.
module tb_otg_hpi_cycle_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default-parameter DUT ----------------
  logic        d_valid = 0, d_write = 0, d_chip_rst = 0;
  logic [1:0]  d_addr = 0;
  logic [15:0] d_wdata = 0, d_din = 0;
  logic        d_ready, d_rsp_valid, d_cs_n, d_rd_n, d_wr_n, d_rst_n, d_oe;
  logic [15:0] d_rdata, d_dout;
  logic [1:0]  d_oaddr;
  logic [2:0]  d_dbg;

  otg_hpi_cycle_ctrl u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(d_valid), .req_ready(d_ready), .req_write(d_write),
    .req_addr(d_addr), .req_wdata(d_wdata),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rdata), .chip_rst_req(d_chip_rst),
    .otg_addr(d_oaddr), .otg_cs_n(d_cs_n), .otg_rd_n(d_rd_n), .otg_wr_n(d_wr_n),
    .otg_rst_n(d_rst_n), .otg_data_out(d_dout), .otg_data_oe(d_oe),
    .otg_data_in(d_din), .dbg_state(d_dbg)
  );

  // ---------------- (3,4,2,1) DUT ----------------
  logic        p_valid = 0, p_write = 0;
  logic [15:0] p_wdata = 0, p_din = 16'h1111;
  logic        p_ready, p_rsp_valid, p_cs_n, p_rd_n, p_wr_n, p_rst_n, p_oe;
  logic [15:0] p_rdata, p_dout;
  logic [1:0]  p_oaddr;
  logic [2:0]  p_dbg;

  otg_hpi_cycle_ctrl #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2), .RECOVERY_CYC(1)) u_p (
    .clk(clk), .reset_n(reset_n),
    .req_valid(p_valid), .req_ready(p_ready), .req_write(p_write),
    .req_addr(2'd1), .req_wdata(p_wdata),
    .rsp_valid(p_rsp_valid), .rsp_rdata(p_rdata), .chip_rst_req(1'b0),
    .otg_addr(p_oaddr), .otg_cs_n(p_cs_n), .otg_rd_n(p_rd_n), .otg_wr_n(p_wr_n),
    .otg_rst_n(p_rst_n), .otg_data_out(p_dout), .otg_data_oe(p_oe),
    .otg_data_in(p_din), .dbg_state(p_dbg)
  );

  // ---------------- all-zero-parameter DUT ----------------
  logic        z_valid = 0, z_write = 0;
  logic [15:0] z_wdata = 0, z_din = 16'h2222;
  logic        z_ready, z_rsp_valid, z_cs_n, z_rd_n, z_wr_n, z_rst_n, z_oe;
  logic [15:0] z_rdata, z_dout;
  logic [1:0]  z_oaddr;
  logic [2:0]  z_dbg;

  otg_hpi_cycle_ctrl #(.SETUP_CYC(0), .STROBE_CYC(0), .HOLD_CYC(0), .RECOVERY_CYC(0),
                       .RESET_CYC(0)) u_z (
    .clk(clk), .reset_n(reset_n),
    .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
    .req_addr(2'd3), .req_wdata(z_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .chip_rst_req(1'b0),
    .otg_addr(z_oaddr), .otg_cs_n(z_cs_n), .otg_rd_n(z_rd_n), .otg_wr_n(z_wr_n),
    .otg_rst_n(z_rst_n), .otg_data_out(z_dout), .otg_data_oe(z_oe),
    .otg_data_in(z_din), .dbg_state(z_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on the default DUT, sampled at the negedge after each edge Tk.
  task automatic d_txn(input logic wr, input logic [1:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rdata);
    check("ready_before_accept", d_ready, 1'b1);
    d_valid = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      check($sformatf("cs_n_T%0d", k + 1), d_cs_n, (k <= 3) ? 1'b0 : 1'b1);
      check($sformatf("wr_n_T%0d", k + 1), d_wr_n, (wr && (k == 1 || k == 2)) ? 1'b0 : 1'b1);
      check($sformatf("rd_n_T%0d", k + 1), d_rd_n, (!wr && (k == 1 || k == 2)) ? 1'b0 : 1'b1);
      check($sformatf("oe_T%0d", k + 1), d_oe, (wr && k <= 3) ? 1'b1 : 1'b0);
      check($sformatf("rsp_valid_T%0d", k + 1), d_rsp_valid, (k == 3) ? 1'b1 : 1'b0);
      check($sformatf("ready_T%0d", k + 1), d_ready, (k >= 5) ? 1'b1 : 1'b0);
      if (k == 0) begin
        check("otg_addr", d_oaddr, addr);
        if (wr) check("otg_data_out", d_dout, wdata);
      end
      if (k == 3) check("rsp_rdata", d_rdata, exp_rdata);
      @(negedge clk);
    end
  endtask

  // Continuous req_valid on u_p (sel=1) or u_z (sel=0); accepts must be 'gap' apart.
  task automatic rate_test(input bit sel, input int gap);
    int t[4];
    int waited;
    if (sel) p_valid = 1'b1; else z_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (!(sel ? p_ready : z_ready) && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("rate%0d_ready_timeout_%0d", sel, i), (waited < 40), 1'b1);
      check($sformatf("rate%0d_cs_idle_%0d", sel, i), sel ? p_cs_n : z_cs_n, 1'b1);
      @(posedge clk);
      @(negedge clk);
      t[i] = cyc;
      check($sformatf("rate%0d_cs_low_%0d", sel, i), sel ? p_cs_n : z_cs_n, 1'b0);
      if (sel) begin p_write = ~p_write; p_wdata = p_wdata + 16'h0101; end
      else     begin z_write = ~z_write; z_wdata = z_wdata + 16'h0101; end
    end
    if (sel) p_valid = 1'b0; else z_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      check($sformatf("rate%0d_gap_%0d", sel, i), t[i] - t[i-1], gap);
  endtask

  initial begin
    int low_cnt;
    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_ready", d_ready, 1'b0);
    check("rst_cs_n", d_cs_n, 1'b1);
    check("rst_rd_wr_n", {d_rd_n, d_wr_n}, 2'b11);
    check("rst_otg_rst_n", d_rst_n, 1'b1);
    check("rst_oe", d_oe, 1'b0);
    check("rst_addr_dout", {d_oaddr, d_dout}, 18'd0);
    check("rst_rsp", {d_rsp_valid, d_rdata}, 17'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", d_ready, 1'b1);

    // ---- default write then read ----
    d_txn(1'b1, 2'd2, 16'h1234, 16'h0000);
    d_din = 16'hBEEF;
    d_txn(1'b0, 2'd0, 16'h0000, 16'hBEEF);
    d_din = 16'h5555;
    @(negedge clk);
    check("rdata_held", d_rdata, 16'hBEEF);

    // ---- chip reset has priority over a simultaneous request ----
    d_chip_rst = 1'b1; d_valid = 1'b1; d_write = 1'b1; d_addr = 2'd1; d_wdata = 16'hA5A5;
    @(posedge clk);
    @(negedge clk);
    d_chip_rst = 1'b0;
    check("chiprst_no_accept", d_cs_n, 1'b1);
    low_cnt = 0;
    while (d_rst_n == 1'b0 && low_cnt < 40) begin
      low_cnt++;
      @(negedge clk);
    end
    check("chiprst_low_cycles", low_cnt, 16);
    check("chiprst_recover_ready", d_ready, 1'b0);
    @(negedge clk);
    check("chiprst_idle_ready", d_ready, 1'b1);
    check("chiprst_cs_still_high", d_cs_n, 1'b1);
    @(negedge clk);
    d_valid = 1'b0;
    check("chiprst_then_accept", d_cs_n, 1'b0);
    check("chiprst_then_oe", d_oe, 1'b1);
    repeat (8) @(negedge clk);

    // ---- accept rate with (3,4,2,1) and with all-zero parameters ----
    rate_test(1'b1, 10);
    rate_test(1'b0, 4);
    repeat (12) @(negedge clk);

    // ---- asynchronous reset during the strobe of a write ----
    check("abort_ready_before", d_ready, 1'b1);
    d_valid = 1'b1; d_write = 1'b1; d_addr = 2'd3; d_wdata = 16'h0F0F;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    @(negedge clk);
    check("abort_in_strobe", {d_cs_n, d_wr_n, d_oe}, 3'b001);
    #1 reset_n = 1'b0;
    #1;
    check("abort_cs_n", d_cs_n, 1'b1);
    check("abort_rd_wr_n", {d_rd_n, d_wr_n}, 2'b11);
    check("abort_oe", d_oe, 1'b0);
    check("abort_ready", d_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_rsp_%0d", k), d_rsp_valid, 1'b0);
      check($sformatf("abort_ready_%0d", k), d_ready, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/otg_hpi_cycle_ctrl.md
# otg_hpi_cycle_ctrl

Bus-cycle engine between the SoC-side HPI data/address/control registers and the CY7C67200 OTG controller's Host Port Interface pins. It accepts single 16-bit read or write requests through a valid/ready handshake and generates the HPI strobe sequence with programmable setup, strobe, hold and recovery times. It drives the tri-state data bus enable and returns read data with a one-cycle response pulse. It also sequences the chip hardware reset.

## Interface
Parameters:
- SETUP_CYC, 1: cycles with cs_n low and address valid before the strobe; 0 behaves as 1; max 255.
- STROBE_CYC, 2: cycles with rd_n/wr_n low; 0 behaves as 1; max 255.
- HOLD_CYC, 1: cycles with cs_n low and address/data held after the strobe; 0 behaves as 1; max 255.
- RECOVERY_CYC, 2: cycles with cs_n high before the next request is accepted; 0 behaves as 1; max 255.
- RESET_CYC, 16: length of the otg_rst_n low pulse; 0 behaves as 1; max 255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine idle; a request is accepted on a clock edge where req_valid and req_ready are both 1.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse for both reads and writes.
- rsp_rdata  out  16  read data; valid while rsp_valid is 1; holds its value until the next read completes.
- chip_rst_req  in  1  request a chip reset pulse; sampled only in IDLE.
- otg_addr  out  2  HPI address pins.
- otg_cs_n, otg_rd_n, otg_wr_n  out  1 each  HPI strobes, active-low.
- otg_rst_n  out  1  chip reset, active-low.
- otg_data_out  out  16  value driven onto the data pins.
- otg_data_oe  out  1  tri-state enable for the data pins; 1 = drive.
- otg_data_in  in  16  data pins as read back.

## Operation
- All outputs are registered.
- Reset values:
  - req_ready=0 during reset; req_ready=1 on the first clock edge after reset_n deasserts.
  - rsp_valid=0, rsp_rdata=0.
  - otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n = 1.
  - otg_addr=0, otg_data_out=0, otg_data_oe=0.
- The FSM has states IDLE, SETUP, STROBE, HOLD, RECOVER, CHIPRST. One 8-bit down-counter is loaded on each state entry with (parameter − 1).
- IDLE:
  - If chip_rst_req is 1, go to CHIPRST. chip_rst_req has priority over req_valid.
  - Otherwise, on a handshake: latch the request, drive otg_addr, set otg_cs_n=0, set otg_data_oe=req_write, load otg_data_out from req_wdata, and go to SETUP.
- SETUP: lasts SETUP_CYC cycles, then STROBE. The strobe pin for the request type (otg_wr_n for writes, otg_rd_n for reads) goes low on entry to STROBE.
- STROBE:
  - Lasts STROBE_CYC cycles.
  - On the exiting edge, the strobe returns high; for a read, otg_data_in is captured into rsp_rdata on that same edge.
  - rsp_valid pulses during the first HOLD cycle.
- HOLD: lasts HOLD_CYC cycles; otg_addr, otg_data_out and otg_data_oe are unchanged. On exit, otg_cs_n=1 and otg_data_oe=0.
- RECOVER: lasts RECOVERY_CYC cycles, then IDLE with req_ready=1.
- CHIPRST: otg_rst_n=0 for RESET_CYC cycles, then RECOVER.
- req_ready is 1 only in IDLE and drops on the accept edge. No request queueing; req_* inputs are ignored outside IDLE.
- Asynchronous reset mid-cycle: returns to IDLE with all pins at their reset values immediately. No response is produced for the aborted request.

## Timing
- Accept edge = T0.
- With the defaults:
  - otg_cs_n is low during T1–T4.
  - the strobe is low during T2–T3.
  - rsp_valid is high during T4.
  - req_ready returns high at T6.
- Generally, the busy time is SETUP+STROBE+HOLD+RECOVERY cycles from T0 until req_ready is high again.
- otg_data_oe rises with the otg_cs_n fall and falls with the otg_cs_n rise, so data is never driven outside chip-select.
- Back-to-back requests: one accept per (SETUP+STROBE+HOLD+RECOVERY) cycles at most. req_valid held high continuously yields exactly that rate.

## Test plan
- Write with defaults: addr=2, wdata=0x1234. The strobe waveform must match the Timing section (otg_cs_n low T1–T4, otg_wr_n low T2–T3), otg_data_oe high only while otg_cs_n is low, and rsp_valid pulses at T4.
- Read with defaults, addr=0, otg_data_in=0xBEEF during the strobe: otg_rd_n low T2–T3, otg_data_oe stays 0, rsp_rdata=0xBEEF with rsp_valid at T4.
- Parameters (3,4,2,1), continuous req_valid with alternating write/read: accept edges exactly 10 cycles apart, no overlap of otg_cs_n cycles.
- chip_rst_req and req_valid asserted together in IDLE: otg_rst_n low for exactly 16 cycles, then RECOVER, then the request is accepted.
- reset_n asserted during STROBE: otg_cs_n, otg_rd_n, otg_wr_n go to 1 and otg_data_oe to 0 without waiting for a clock; no rsp_valid; req_ready=1 on the first edge after release.
- Zero-valued parameters: all four parameters set to 0 behave identically to all set to 1, i.e. a 4-cycle busy period.
